sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_pkg.sv | 70 +++++++
 rtl/sram_responder_if.sv | 25 ++
 rtl/sram_array.sv | 33 +++
 rtl/sram_responder.sv | 108 ++++++++++
 tb/tb_sram_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types, constants and lane helpers for the SRAM responder and its storage array.
package sram_pkg;

  localparam logic [31:0] MEM_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Illegal size encodings and misaligned sub-word accesses both fault.
  function automatic logic access_fault(input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << lo;
      SZ_H:    be = 4'b0011 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] wdata);
    logic [31:0] d;
    case (sz)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_format(input logic [1:0] sz, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    logic [31:0] d;
    shifted = word >> {lo, 3'b000};
    case (sz)
      SZ_B:    d = {24'h0, shifted[7:0]};
      SZ_H:    d = {16'h0, shifted[15:0]};
      default: d = shifted;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Request/response bus between an initiator (master) and the SRAM responder (slave).
interface sram_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_array.sv
// Synchronous byte-strobed 32-bit storage with one shared read/write port; contents survive reset.
module sram_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // The read register only updates on a read, so it holds the last loaded word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_responder.sv
// Single-outstanding SRAM responder: accepts one request, waits LATENCY cycles, then presents a response.
module sram_responder
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE    = MEM_BASE,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input logic              clk,
  input logic              rst,
  sram_responder_if.slave  bus
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) << 2;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        err_q, err_d;

  req_t        live;
  req_t        cur;
  logic [31:0] offset;
  logic        fault;
  logic        enterRsp;
  logic [31:0] memRdata;

  assign live = '{wen: bus.req_wen, size: bus.req_size, addr: bus.req_addr, wdata: bus.req_wdata};

  // With LATENCY == 1 the access happens on the accepting edge, so use the live request in IDLE.
  assign cur    = (state_q == IDLE) ? live : req_q;
  assign offset = cur.addr - BASE;
  assign fault  = (cur.addr < BASE) || ({1'b0, offset} >= SPAN) || access_fault(cur.size, cur.addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    err_d    = err_q;
    enterRsp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d = live;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d  = RESP;
            enterRsp = 1'b1;
            err_d    = fault;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          enterRsp = 1'b1;
          err_d    = fault;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = (state_q == RESP) && err_q;
    bus.rsp_rdata = 32'h0;
    if ((state_q == RESP) && !err_q && !req_q.wen)
      bus.rsp_rdata = load_format(req_q.size, req_q.addr[1:0], memRdata);
  end

  sram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk     (clk),
    .en_i    (enterRsp && !fault),
    .we_i    (cur.wen),
    .be_i    (lane_strobe(cur.size, cur.addr[1:0])),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (lane_data(cur.size, cur.wdata)),
    .rdata_o (memRdata)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Directed-vector bench for sram_responder: default LATENCY=2 build plus a LATENCY=1 build.
module tb_sram_responder;
  import sram_pkg::*;

  typedef struct {
    logic        wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sram_responder_if bus0 ();
  sram_responder_if bus1 ();

  sram_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sram_responder #(.BASE(32'h8000_0000), .DEPTH(1024), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Waits at negedges for rsp_valid on the L=2 DUT; lat counts edges since acceptance.
  task automatic waitRsp(output int lat);
    @(negedge clk);
    lat = 1;
    while (!bus0.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic driveReq(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input string name);
    int n;
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_wen   = wen;
    bus0.req_size  = size;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " req_ready"}, 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    bus0.req_wen   = ~wen;
    bus0.req_size  = 2'($urandom_range(0, 3));
    bus0.req_addr  = $urandom;
    bus0.req_wdata = $urandom;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    int lat;
    driveReq(v.wen, v.size, v.addr, v.wdata, name);
    waitRsp(lat);
    checkOutput({name, " latency"}, 32'(lat), 32'd2);
    checkOutput({name, " rdata"}, bus0.rsp_rdata, v.expRdata);
    checkOutput({name, " err"}, 32'(bus0.rsp_err), 32'(v.expErr));
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " ready_after"}, 32'(bus0.req_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_size = 2'b10;
    bus0.req_addr  = 32'h0; bus0.req_wdata = 32'h0; bus0.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_wen = 1'b0; bus1.req_size = 2'b10;
    bus1.req_addr  = 32'h0; bus1.req_wdata = 32'h0; bus1.rsp_ready = 1'b1;

    // Reset state, before and after clock edges.
    #1;
    checkOutput("reset rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("reset req_ready", 32'(bus0.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset rsp_err", 32'(bus0.rsp_err), 32'd0);
    checkOutput("reset rsp_rdata", bus0.rsp_rdata, 32'd0);
    rst = 1'b0;

    //           wen   size   addr           wdata          expRdata       expErr
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, SZ_B, 32'h8000_0013, 32'h0000_00A5, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0000_0000, 32'hA500_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 32'h8000_0012, 32'h0000_0000, 32'h0000_A500, 1'b0});
    vecs.push_back('{1'b0, SZ_B, 32'h8000_0013, 32'h0000_0000, 32'h0000_00A5, 1'b0});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0000, 32'h1122_3344, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0FFC, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 32'h8000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, SZ_W, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0000, 32'h0000_0000, 32'h1122_3344, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0FFC, 32'h0000_0000, 32'h0F0F_0F0F, 1'b0});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_1000, 32'h9999_9999, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0000, 32'h0000_0000, 32'h1122_3344, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'b11, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0002, 32'h5555_5555, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, SZ_B, 32'h8000_0011, 32'hFFFF_FF5A, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0010, 32'h0000_0000, 32'hA500_5A00, 1'b0});
    vecs.push_back('{1'b1, SZ_H, 32'h8000_0002, 32'h0000_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, SZ_W, 32'h8000_0000, 32'h0000_0000, 32'hBEEF_3344, 1'b0});
    vecs.push_back('{1'b0, SZ_H, 32'h8000_0011, 32'h0000_0000, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, SZ_W, 32'h8000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0});

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: response held for five cycles must stay stable.
    bus0.rsp_ready = 1'b0;
    driveReq(1'b0, SZ_W, 32'h8000_0010, 32'h0, "bp");
    waitRsp(lat);
    checkOutput("bp latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp valid c%0d", k), 32'(bus0.rsp_valid), 32'd1);
      checkOutput($sformatf("bp rdata c%0d", k), bus0.rsp_rdata, 32'hA500_5A00);
      checkOutput($sformatf("bp err c%0d", k), 32'(bus0.rsp_err), 32'd0);
      checkOutput($sformatf("bp req_ready c%0d", k), 32'(bus0.req_ready), 32'd0);
      @(negedge clk);
    end
    bus0.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp ready_after", 32'(bus0.req_ready), 32'd1);
    checkOutput("bp valid_after", 32'(bus0.rsp_valid), 32'd0);

    // Reset while a store waits: the store must be dropped.
    driveReq(1'b1, SZ_W, 32'h8000_0020, 32'h1234_5678, "rstmid");
    @(negedge clk);
    checkOutput("rstmid in_wait valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("rstmid in_wait ready", 32'(bus0.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rstmid rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    checkOutput("rstmid req_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('{1'b0, SZ_W, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b0}, "rstmid reload");

    // LATENCY=1 build: store, then back-to-back loads.
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_wen = 1'b1; bus1.req_size = SZ_W;
    bus1.req_addr = 32'h8000_0040; bus1.req_wdata = 32'h0BAD_F00D;
    checkOutput("lat1 store ready", 32'(bus1.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat1 store valid", 32'(bus1.rsp_valid), 32'd1);
    checkOutput("lat1 store err", 32'(bus1.rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat1 ready_after", 32'(bus1.req_ready), 32'd1);
    bus1.req_valid = 1'b1; bus1.req_wen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("lat1 b2b valid c%0d", k), 32'(bus1.rsp_valid), 32'(k % 2 == 0));
      checkOutput($sformatf("lat1 b2b ready c%0d", k), 32'(bus1.req_ready), 32'(k % 2 != 0));
      if (k % 2 == 0)
        checkOutput($sformatf("lat1 b2b rdata c%0d", k), bus1.rsp_rdata, 32'h0BAD_F00D);
    end
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
